// File: rtl/bsg_csa_accumulator_iterative.sv
// Carry-save accumulator for iterative multipliers: v_o two edges after final pair, one-cycle resolve; ready_o low while resolving/holding.
// Define BSG_CSA_ACCUMULATOR_SIGNED_EN to sign-extend operands (Booth / signed partial products); otherwise zero-extend.
module bsg_csa_accumulator_iterative #(
    parameter int width_p  = 32,
    parameter int steps_p  = 8,
    parameter int shift_p  = 4,
    localparam int res_width_lp = width_p + shift_p * (steps_p - 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    output logic                    ready_o,
    input  logic [width_p-1:0]      opA_i,
    input  logic [width_p-1:0]      opB_i,
    output logic                    v_o,
    output logic [res_width_lp-1:0] result_o,
    input  logic                    yumi_i
);

    localparam int step_width_lp = (steps_p > 1) ? $clog2(steps_p) : 1;
    localparam int ext_bits_lp   = res_width_lp - width_p;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_e;

    state_e                   state_q, state_d;
    logic [step_width_lp-1:0] step_q, step_d;
    logic [res_width_lp-1:0]  sum_q, sum_d;
    logic [res_width_lp-1:0]  carry_q, carry_d;
    logic [res_width_lp-1:0]  result_q, result_d;

    logic                     fill_a, fill_b;
    logic [res_width_lp-1:0]  ext_a, ext_b;
    logic [res_width_lp-1:0]  shift_a, shift_b;
    logic [31:0]              shamt;
    logic [res_width_lp-1:0]  fa_s, fa_c, csa_sum, csa_carry;
    logic                     accept;
    logic                     last_step;

`ifdef BSG_CSA_ACCUMULATOR_SIGNED_EN
    assign fill_a = opA_i[width_p-1];
    assign fill_b = opB_i[width_p-1];
`else
    assign fill_a = 1'b0;
    assign fill_b = 1'b0;
`endif

    // With a single step the result is exactly width_p bits, so there is nothing to extend.
    generate
        if (ext_bits_lp > 0) begin : g_ext
            assign ext_a = {{ext_bits_lp{fill_a}}, opA_i};
            assign ext_b = {{ext_bits_lp{fill_b}}, opB_i};
        end else begin : g_noext
            logic unused_fill;
            assign unused_fill = fill_a ^ fill_b;
            assign ext_a = opA_i;
            assign ext_b = opB_i;
        end
    endgenerate

    assign shamt   = 32'(shift_p) * 32'(step_q);
    assign shift_a = ext_a << shamt;
    assign shift_b = ext_b << shamt;

    // 4:2 compress as two full-adder rows; carries weigh 2x and the top carry falls off.
    assign fa_s      = sum_q ^ carry_q ^ shift_a;
    assign fa_c      = ((sum_q & carry_q) | (sum_q & shift_a) | (carry_q & shift_a)) << 1;
    assign csa_sum   = fa_s ^ shift_b ^ fa_c;
    assign csa_carry = ((fa_s & shift_b) | (fa_s & fa_c) | (shift_b & fa_c)) << 1;

    assign accept    = v_i & ready_o;
    assign last_step = (step_q == step_width_lp'(steps_p - 1));

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        result_d = result_q;
        ready_o  = 1'b0;
        v_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (accept) begin
                    sum_d   = shift_a;
                    carry_d = shift_b;
                    step_d  = step_width_lp'(1);
                    state_d = (steps_p == 1) ? RESOLVE : ACCUM;
                end
            end
            ACCUM: begin
                ready_o = 1'b1;
                if (accept) begin
                    sum_d   = csa_sum;
                    carry_d = csa_carry;
                    step_d  = step_q + step_width_lp'(1);
                    if (last_step) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                result_d = sum_q + carry_q;
                step_d   = '0;
                state_d  = DONE;
            end
            DONE: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result_o = result_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            step_q   <= '0;
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

endmodule

// File: doc/bsg_csa_accumulator_iterative.md
Name: bsg_csa_accumulator_iterative

Overview:
- Sits directly downstream of the 4-2 carry-save reduction tree in the iterative multipliers.
- Consumes one carry-save pair (A, B) per step; each pair carries weight 2^(shift_p*step).
- Accumulates all steps_p pairs in redundant form, resolves them once with a single carry-propagate add, and holds the binary result for a valid/yumi consumer.
- Replaces per-step carry-propagate adds in the iterative multiplier datapath.

Parameters:
- width_p, 32, width of each incoming carry-save operand (matches tree output width).
- steps_p, 8, number of carry-save pairs per operation; legal range >= 1.
- shift_p, 4, left-shift in bits applied per step index (the multiplier's iter step).
- res_width_lp (local), width_p + shift_p*(steps_p-1), width of accumulator and result.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  1  incoming carry-save pair valid.
- ready_o  output  1  block accepts a pair this cycle.
- opA_i  input  width_p  carry-save operand A.
- opB_i  input  width_p  carry-save operand B.
- v_o  output  1  result valid.
- result_o  output  res_width_lp  resolved sum of all pairs, modulo 2^res_width_lp.
- yumi_i  input  1  consumer takes result; legal only while v_o=1.

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clk_i and reset_i.
- Handshake: a pair is accepted on a rising edge where v_i & ready_o.
- State registers: state_r, step_r (clog2(steps_p) bits), sum_r and carry_r (res_width_lp each), result_r.
- Reset values: state_r=IDLE, step_r=0, sum_r=carry_r=result_r=0. After reset, ready_o=1, v_o=0, result_o=0.
- Reset asserted mid-operation aborts it: the partial accumulation is discarded and no v_o is produced.
- Operand extension: each operand is extended to res_width_lp bits (see Optional Feature), then shifted left by shift_p*step_r. Bits above res_width_lp are dropped.
- State IDLE: ready_o=1, v_o=0.
  - On accept: sum_r=ext(A)<<0, carry_r=ext(B)<<0 (load, no add), step_r=1.
  - Next state is RESOLVE if steps_p==1, else ACCUM.
- State ACCUM: ready_o=1, v_o=0.
  - On accept: {sum_r,carry_r} = 4:2 carry-save compress of sum_r, carry_r, shifted A, shifted B. The compressor carry-out shifts left by 1; the MSB carry is dropped.
  - step_r increments. If step_r==steps_p-1 at accept, go to RESOLVE.
  - No accept: hold all state. Gaps in v_i are legal.
- State RESOLVE: ready_o=0, v_o=0. Exactly one cycle: result_r = sum_r + carry_r (mod 2^res_width_lp), step_r=0, go to DONE.
- State DONE: ready_o=0, v_o=1, result_o=result_r.
  - yumi_i=1: go to IDLE.
  - Otherwise hold. Result is stable until taken.
- Latency: final pair accepted at edge k gives v_o=1 from edge k+2. Earliest next accept is the cycle after yumi.
- result_o reflects result_r in every state, showing the last result or 0 after reset. Consumers qualify it with v_o.
- v_i while ready_o=0 is ignored; the producer must hold the pair.
- Single-step operation (steps_p==1) is legal and must not under- or overflow step_r.
- Arithmetic correctness requirement: result_o == (Σ_{i=0}^{steps_p-1} (ext(A_i)+ext(B_i))<<(shift_p*i)) mod 2^res_width_lp.

Optional Feature:
- Macro: BSG_CSA_ACCUMULATOR_SIGNED_EN.
- Defined: each operand is sign-extended from bit width_p-1 to res_width_lp before shifting. Use this for Booth / signed partial products.
- Undefined: operands are zero-extended. No other behaviour differs.

Test Plan:
- width_p=8, steps_p=4, shift_p=4 (res 20 bits); pairs (0x12,0x03), (0x00,0x01), (0x05,0x05), (0x00,0x00) back-to-back -> v_o rises 2 cycles after 4th accept, result_o=0x00A25.
- Same config, all pairs (0xFF,0xFF), macro off -> result_o=0x1FFDE (0x21FFDE truncated to 20 bits).
- Macro on, pairs (0xFF,0x00), (0,0), (0,0), (0,0) -> result_o=0xFFFFF; macro off, same stimulus -> 0x000FF.
- Random v_i gaps plus yumi_i held low 5 cycles -> ready_o=0 and v_i ignored during RESOLVE/DONE; result_o stable for all 5 cycles; IDLE re-entered on the cycle after yumi_i.
- reset_i pulsed after 2 of 4 pairs, then a fresh 4-pair operation -> no v_o from the aborted operation; the new result is correct and unaffected by stale sum_r/carry_r.
- steps_p=1, pair (0x7F,0x01) -> result_o=0x80 at edge k+2; random 1000-operation compare against the reference sum formula.
